hwpe_stream_addressgen_sched: RTL and testbench

Job scheduler that shares one `hwpe_stream_addressgen` instance between `NB_REQ` requesters (streamers or engine FSMs). It accepts per-requester jobs as `ctrl_addressgen_t` descriptors and arbitrates round-robin. For each job it loads the descriptor, clears and primes the address generator, and drives its `enable_i` once per accepted downstream address beat. It pulses a per-requester `done` on completion. It sits between engine control and the address generator / TCDM request path.

---
 rtl/hwpe_stream_addressgen_sched_if.sv | 50 +++++
 rtl/hwpe_stream_addressgen_sched.sv | 166 ++++++++++++++++
 tb/tb_hwpe_stream_addressgen_sched.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_addressgen_sched_if.sv
// rtl/hwpe_stream_addressgen_sched_if.sv - descriptor/flag types and the scheduler's requester/address-generator bus
package hwpe_stream_addressgen_sched_pkg;
    typedef struct packed {
        logic [31:0] base_addr;
        logic [31:0] trans_size;
        logic [15:0] line_stride;
        logic [15:0] line_length;
        logic [15:0] feat_stride;
        logic [15:0] feat_length;
        logic [15:0] feat_roll;
        logic        loop_outer;
        logic        realign_type;
        logic [7:0]  step;
    } ctrl_addressgen_t;

    typedef struct packed {
        logic realign;
        logic first;
        logic last;
        logic enable;
        logic in_progress;
    } flags_addressgen_t;
endpackage

interface hwpe_stream_addressgen_sched_if #(
    parameter int NB_REQ = 2
);
    import hwpe_stream_addressgen_sched_pkg::*;

    logic [NB_REQ-1:0]             req_valid_i;
    logic [NB_REQ-1:0]             req_ready_o;
    ctrl_addressgen_t [NB_REQ-1:0] req_ctrl_i;
    logic [NB_REQ-1:0]             done_o;
    logic                          ag_clear_o;
    logic                          ag_enable_o;
    ctrl_addressgen_t              ag_ctrl_o;
    flags_addressgen_t             ag_flags_i;
    logic                          addr_valid_o;
    logic                          addr_ready_i;

    modport slave (
        input  req_valid_i, req_ctrl_i, ag_flags_i, addr_ready_i,
        output req_ready_o, done_o, ag_clear_o, ag_enable_o, ag_ctrl_o, addr_valid_o
    );

    modport master (
        output req_valid_i, req_ctrl_i, ag_flags_i, addr_ready_i,
        input  req_ready_o, done_o, ag_clear_o, ag_enable_o, ag_ctrl_o, addr_valid_o
    );
endinterface

// File: rtl/hwpe_stream_addressgen_sched.sv
// rtl/hwpe_stream_addressgen_sched.sv - round-robin job scheduler sharing one address generator
// Optional stall counter: define HWPE_STREAM_ADDRGEN_SCHED_PERF_EN.
module hwpe_stream_addressgen_sched
    import hwpe_stream_addressgen_sched_pkg::*;
#(
    parameter int NB_REQ   = 2,
    parameter int BEAT_CNT = 16,
    localparam int ID_W    = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          clear_i,
    hwpe_stream_addressgen_sched_if.slave bus,
    output logic                          busy_o,
    output logic [ID_W-1:0]               cur_id_o,
    output logic [31:0]                   stall_cnt_o
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SETUP, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [BEAT_CNT-1:0] beat_q, beat_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  cur_id_q, cur_id_d;
    ctrl_addressgen_t ctrl_q, ctrl_d;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic            beat;
    logic            last_beat;
    logic            unused_flags;

    assign unused_flags = ^bus.ag_flags_i;

    // Two passes: requesters at/after rr_ptr first, then wrap to the low indices.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int j = 0; j < NB_REQ; j++) begin
            if (!grant_found && (j >= int'(rr_ptr_q)) && bus.req_valid_i[j]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(j);
            end
        end
        for (int j = 0; j < NB_REQ; j++) begin
            if (!grant_found && bus.req_valid_i[j]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(j);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        rr_ptr_d = rr_ptr_q;
        cur_id_d = cur_id_q;
        ctrl_d   = ctrl_q;

        bus.req_ready_o  = '0;
        bus.done_o       = '0;
        bus.ag_clear_o   = 1'b0;
        bus.ag_enable_o  = 1'b0;
        bus.addr_valid_o = (state_q == S_RUN) && !clear_i;

        beat      = bus.addr_valid_o && bus.addr_ready_i && enable_i;
        last_beat = (beat_q == BEAT_CNT'(ctrl_q.trans_size - 32'd1));

        if (clear_i) begin
            state_d        = S_IDLE;
            beat_d         = '0;
            rr_ptr_d       = '0;
            cur_id_d       = '0;
            ctrl_d         = '0;
            bus.ag_clear_o = 1'b1;
        end else if (enable_i) begin
            unique case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        bus.req_ready_o[grant_idx] = 1'b1;
                        ctrl_d   = bus.req_ctrl_i[grant_idx];
                        cur_id_d = grant_idx;
                        rr_ptr_d = (int'(grant_idx) == NB_REQ - 1) ? '0 : grant_idx + 1'b1;
                        beat_d   = '0;
                        state_d  = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    bus.ag_clear_o = 1'b1;
                    state_d        = S_SETUP;
                end
                // Lets the generator's registered misalignment flag settle on the new descriptor.
                S_SETUP: begin
                    state_d = (ctrl_q.trans_size == 32'd0) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    if (beat) begin
                        bus.ag_enable_o = 1'b1;
                        if (last_beat) begin
                            beat_d  = '0;
                            state_d = S_DONE;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    bus.done_o[cur_id_q] = 1'b1;
                    state_d              = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            rr_ptr_q <= '0;
            cur_id_q <= '0;
            ctrl_q   <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            rr_ptr_q <= rr_ptr_d;
            cur_id_q <= cur_id_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign cur_id_o      = cur_id_q;
    assign bus.ag_ctrl_o = ctrl_q;

`ifdef HWPE_STREAM_ADDRGEN_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (clear_i) begin
            stall_d = '0;
        end else if (enable_i && bus.addr_valid_o && !bus.addr_ready_i && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

    // A non-empty job must leave the generator idle by the time it is reported done.
    a_idle_on_done: assert property (@(posedge clk_i) disable iff (rst_i || clear_i)
        (state_q == S_RUN && state_d == S_DONE) |=> !bus.ag_flags_i.in_progress);

endmodule

// File: tb/tb_hwpe_stream_addressgen_sched.sv
// tb/tb_hwpe_stream_addressgen_sched.sv - table-driven, scoreboarded bench for hwpe_stream_addressgen_sched
module tb_hwpe_stream_addressgen_sched;
    import hwpe_stream_addressgen_sched_pkg::*;

    typedef struct {
        logic [1:0] valid;
        bit         hold;
        int         size0;
        int         size1;
        int         exp_gnt;
        int         mode;
        int         freeze_at;
        int         exp_lat;
    } vec_t;

    typedef struct {
        int id;
        int beats;
    } sb_t;

    logic        clk;
    logic        rst_i;
    logic        enable_i;
    logic        clear_i;
    logic        busy_o;
    logic [0:0]  cur_id_o;
    logic [31:0] stall_cnt_o;

    int checks;
    int failures;
    int mon_beats;
    bit prev_valid;
    bit prev_beat;
    bit prev_clr;
    sb_t sb_q[$];
    vec_t vecs[11];

    hwpe_stream_addressgen_sched_if #(.NB_REQ(2)) bus ();

    hwpe_stream_addressgen_sched #(
        .NB_REQ  (2),
        .BEAT_CNT(16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .clear_i    (clear_i),
        .bus        (bus),
        .busy_o     (busy_o),
        .cur_id_o   (cur_id_o),
        .stall_cnt_o(stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic ctrl_addressgen_t mk_ctrl(input int size, input int base);
        ctrl_addressgen_t c;
        c             = '0;
        c.base_addr   = base;
        c.trans_size  = size;
        c.line_stride = 16'd4;
        c.line_length = 16'd1;
        c.step        = 8'd4;
        return c;
    endfunction

    // Scoreboard consumer and per-cycle protocol checks.
    always @(negedge clk) begin
        sb_t e;
        if (!rst_i) begin
            if (bus.req_ready_o != '0) mon_beats = 0;
            if (bus.ag_enable_o) begin
                chk("ag_enable_qual", {bus.addr_ready_i, enable_i, clear_i}, 3'b110);
                mon_beats++;
            end
            if (prev_valid && !prev_beat && !prev_clr)
                chk("addr_valid_hold", bus.addr_valid_o, 1);
            if (bus.done_o != '0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", bus.done_o, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_id", bus.done_o, 1 << e.id);
                    chk("done_beats", mon_beats, e.beats);
                end
            end
        end
        prev_valid = bus.addr_valid_o;
        prev_beat  = bus.ag_enable_o;
        prev_clr   = clear_i | rst_i;
    end

    task automatic run_vec(input vec_t v);
        int  lat;
        int  run_idx;
        int  size_g;
        bit  got;
        size_g = (v.exp_gnt == 0) ? v.size0 : v.size1;
        @(posedge clk); #1;
        bus.req_valid_i   = v.valid;
        bus.req_ctrl_i[0] = mk_ctrl(v.size0, 'h1000);
        bus.req_ctrl_i[1] = mk_ctrl(v.size1, 'h2000);
        bus.addr_ready_i  = 1'b1;
        enable_i          = 1'b1;
        got = 1'b0;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (bus.req_ready_o != '0) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("accept_seen", got, 1);
        if (!got) return;
        chk("grant_onehot", bus.req_ready_o, 1 << v.exp_gnt);
        sb_q.push_back('{v.exp_gnt, size_g});
        lat     = 0;
        run_idx = 0;
        got     = 1'b0;
        while (!got && lat < 200) begin
            @(posedge clk); #1;
            if (!v.hold) begin
                bus.req_valid_i = '0;
                bus.req_ctrl_i  = '0;
            end
            if (bus.addr_valid_o) begin
                bus.addr_ready_i = (v.mode == 1) ? (run_idx % 2 == 0) : 1'b1;
                enable_i = (v.freeze_at >= 0 && run_idx >= v.freeze_at && run_idx < v.freeze_at + 4) ? 1'b0 : 1'b1;
                run_idx++;
            end else begin
                bus.addr_ready_i = 1'b1;
                enable_i         = 1'b1;
            end
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk("clear_pulse", bus.ag_clear_o, 1);
                chk("cur_id", cur_id_o, v.exp_gnt);
                chk("busy_in_job", busy_o, 1);
                chk("ctrl_latched", bus.ag_ctrl_o.trans_size, size_g);
            end
            if (bus.done_o != '0) got = 1'b1;
        end
        chk("done_seen", got, 1);
        chk("latency", lat, v.exp_lat);
        chk("ctrl_held", bus.ag_ctrl_o.trans_size, size_g);
    endtask

    initial begin
        int  nb;
        int  w;
        bit  got;
        // valid hold size0 size1 gnt mode freeze lat
        vecs[0]  = '{2'b01, 1'b0, 5, 0, 0, 0, -1, 8};
        vecs[1]  = '{2'b01, 1'b0, 4, 0, 0, 1, -1, 10};
        vecs[2]  = '{2'b10, 1'b0, 0, 0, 1, 0, -1, 3};
        vecs[3]  = '{2'b11, 1'b1, 2, 2, 0, 0, -1, 5};
        vecs[4]  = '{2'b11, 1'b1, 2, 2, 1, 0, -1, 5};
        vecs[5]  = '{2'b11, 1'b1, 2, 2, 0, 0, -1, 5};
        vecs[6]  = '{2'b11, 1'b1, 2, 2, 1, 0, -1, 5};
        vecs[7]  = '{2'b11, 1'b1, 2, 2, 0, 0, -1, 5};
        vecs[8]  = '{2'b11, 1'b0, 2, 2, 1, 0, -1, 5};
        vecs[9]  = '{2'b01, 1'b0, 1, 0, 0, 0, -1, 4};
        vecs[10] = '{2'b10, 1'b0, 0, 6, 1, 0, 2, 13};

        checks     = 0;
        failures   = 0;
        mon_beats  = 0;
        rst_i      = 1'b1;
        enable_i   = 1'b1;
        clear_i    = 1'b0;
        bus.req_valid_i  = '0;
        bus.req_ctrl_i   = '0;
        bus.ag_flags_i   = '0;
        bus.addr_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_ag_clear", bus.ag_clear_o, 0);
        chk("rst_ag_enable", bus.ag_enable_o, 0);
        chk("rst_addr_valid", bus.addr_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cur_id", cur_id_o, 0);
        chk("rst_ag_ctrl", bus.ag_ctrl_o.trans_size, 0);
        chk("rst_stall", stall_cnt_o, 0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

`ifdef HWPE_STREAM_ADDRGEN_SCHED_PERF_EN
        chk("stall_cnt", stall_cnt_o, 3);
`else
        chk("stall_cnt", stall_cnt_o, 0);
`endif

        // Mid-job clear: drop an 8-beat job after its 2nd beat.
        @(posedge clk); #1;
        bus.req_valid_i   = 2'b01;
        bus.req_ctrl_i[0] = mk_ctrl(8, 'h3000);
        got = 1'b0;
        for (w = 0; w < 50; w++) begin
            @(negedge clk);
            if (bus.req_ready_o != '0) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("clr_accept", got, 1);
        nb = 0;
        w  = 0;
        while (nb < 2 && w < 50) begin
            @(posedge clk); #1;
            bus.req_valid_i = '0;
            @(negedge clk);
            if (bus.ag_enable_o) nb++;
            w++;
        end
        chk("clr_two_beats", nb, 2);
        @(posedge clk); #1;
        clear_i = 1'b1;
        @(negedge clk);
        chk("clr_ag_clear", bus.ag_clear_o, 1);
        chk("clr_no_enable", bus.ag_enable_o, 0);
        @(posedge clk); #1;
        clear_i = 1'b0;
        @(negedge clk);
        chk("clr_busy", busy_o, 0);
        chk("clr_ctrl", bus.ag_ctrl_o.trans_size, 0);
        chk("clr_base", bus.ag_ctrl_o.base_addr, 0);
        chk("clr_cur_id", cur_id_o, 0);
        chk("clr_no_done", bus.done_o, 0);
        repeat (4) @(negedge clk);

        run_vec('{2'b11, 1'b0, 3, 7, 0, 0, -1, 6});
        chk("stall_after_clear", stall_cnt_o, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
